// File: rtl/pc_stack_unit_pkg.sv
// Shared constants and operation encoding for the program counter / return stack unit.
// Replaces the legacy pic_defines.vh header with package-scoped localparams.
package pc_stack_unit_pkg;

   localparam int PC_WIDTH    = 13;
   localparam int STACK_DEPTH = 8;
   localparam int SP_WIDTH    = $clog2(STACK_DEPTH);
   localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);

   localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 13'h000;
   localparam logic [PC_WIDTH-1:0] INT_VECTOR   = 13'h004;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_INC  = 3'd1,
      OP_PCL  = 3'd2,
      OP_GOTO = 3'd3,
      OP_CALL = 3'd4,
      OP_RET  = 3'd5,
      OP_INT  = 3'd6
   } pc_op_e;

   // Requests are one-hot by contract; anything else resolves to the highest-priority op.
   function automatic pc_op_e f_sel_op(input logic int_en,
                                       input logic ret_en,
                                       input logic call_en,
                                       input logic goto_en,
                                       input logic pcl_wr_en,
                                       input logic pc_inc);
      pc_op_e op;
      if (int_en)         op = OP_INT;
      else if (ret_en)    op = OP_RET;
      else if (call_en)   op = OP_CALL;
      else if (goto_en)   op = OP_GOTO;
      else if (pcl_wr_en) op = OP_PCL;
      else if (pc_inc)    op = OP_INC;
      else                op = OP_NONE;
      return op;
   endfunction

endpackage

// File: rtl/pc_stack_unit_stack.sv
// Circular hardware return stack: push/pop with saturating depth and sticky
// overflow/underflow flags. Storage is never cleared; reset only rewinds pointers.
module hw_return_stack
   import pc_stack_unit_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [PC_WIDTH-1:0]    i_push_data,
   output logic [PC_WIDTH-1:0]    o_pop_data,
   output logic [DEPTH_WIDTH-1:0] o_depth,
   output logic                   o_ovf,
   output logic                   o_unf
);

   localparam logic [DEPTH_WIDTH-1:0] DEPTH_FULL = DEPTH_WIDTH'(STACK_DEPTH);

   logic [PC_WIDTH-1:0]    r_mem [STACK_DEPTH];
   logic [SP_WIDTH-1:0]    r_sp;
   logic [DEPTH_WIDTH-1:0] r_depth;
   logic                   r_ovf;
   logic                   r_unf;
   logic [SP_WIDTH-1:0]    w_sp_dec;

   assign w_sp_dec   = r_sp - SP_WIDTH'(1);
   assign o_pop_data = r_mem[w_sp_dec];
   assign o_depth    = r_depth;
   assign o_ovf      = r_ovf;
   assign o_unf      = r_unf;

   // A push at full depth lands on stack[sp], which is the oldest entry.
   always_ff @(posedge i_clk) begin
      if (!i_rst && i_push) begin
         r_mem[r_sp] <= i_push_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sp    <= '0;
         r_depth <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (i_push) begin
         r_sp <= r_sp + SP_WIDTH'(1);
         if (r_depth == DEPTH_FULL) begin
            r_ovf <= 1'b1;
         end else begin
            r_depth <= r_depth + DEPTH_WIDTH'(1);
         end
      end else if (i_pop) begin
         r_sp <= w_sp_dec;
         if (r_depth == '0) begin
            r_unf <= 1'b1;
         end else begin
            r_depth <= r_depth - DEPTH_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with GOTO/CALL/RETURN/PCL-write/interrupt sequencing and an
// 8-level return stack; drives the program memory fetch address and PCL reads.
module pc_stack_unit
   import pc_stack_unit_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_pc_inc,
   input  logic                   i_goto_en,
   input  logic                   i_call_en,
   input  logic                   i_ret_en,
   input  logic                   i_int_en,
   input  logic                   i_pcl_wr_en,
   input  logic [10:0]            i_k11,
   input  logic [4:0]             i_pclath,
   input  logic [7:0]             i_pcl_data,
   output logic [PC_WIDTH-1:0]    o_pc_out,
   output logic [7:0]             o_pcl_out,
   output logic [DEPTH_WIDTH-1:0] o_stack_depth,
   output logic                   o_stack_ovf,
   output logic                   o_stack_unf
);

   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_pc_next;
   logic [PC_WIDTH-1:0] w_pop_data;
   logic                w_push;
   logic                w_pop;
   pc_op_e              w_op;

   assign w_op = f_sel_op(i_int_en, i_ret_en, i_call_en, i_goto_en, i_pcl_wr_en, i_pc_inc);

   // The fetch already incremented the PC, so CALL and interrupt entry push r_pc as-is.
   always_comb begin
      w_pc_next = r_pc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      case (w_op)
         OP_INT: begin
            w_push    = 1'b1;
            w_pc_next = INT_VECTOR;
         end
         OP_RET: begin
            w_pop     = 1'b1;
            w_pc_next = w_pop_data;
         end
         OP_CALL: begin
            w_push    = 1'b1;
            w_pc_next = {i_pclath[4:3], i_k11};
         end
         OP_GOTO: w_pc_next = {i_pclath[4:3], i_k11};
         OP_PCL:  w_pc_next = {i_pclath, i_pcl_data};
         OP_INC:  w_pc_next = r_pc + PC_WIDTH'(1);
         default: w_pc_next = r_pc;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc <= RESET_VECTOR;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   hw_return_stack u_stack (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_push_data (r_pc),
      .o_pop_data  (w_pop_data),
      .o_depth     (o_stack_depth),
      .o_ovf       (o_stack_ovf),
      .o_unf       (o_stack_unf)
   );

   assign o_pc_out  = r_pc;
   assign o_pcl_out = r_pc[7:0];

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: a behavioural model queues the expected
// state for every driven cycle and the result is compared one cycle later.
module tb_pc_stack_unit;
   import pc_stack_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        pc_inc, goto_en, call_en, ret_en, int_en, pcl_wr_en;
   logic [10:0] k11;
   logic [4:0]  pclath;
   logic [7:0]  pcl_data;
   logic [12:0] pc_out;
   logic [7:0]  pcl_out;
   logic [3:0]  stack_depth;
   logic        stack_ovf, stack_unf;

   pc_stack_unit dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_pc_inc      (pc_inc),
      .i_goto_en     (goto_en),
      .i_call_en     (call_en),
      .i_ret_en      (ret_en),
      .i_int_en      (int_en),
      .i_pcl_wr_en   (pcl_wr_en),
      .i_k11         (k11),
      .i_pclath      (pclath),
      .i_pcl_data    (pcl_data),
      .o_pc_out      (pc_out),
      .o_pcl_out     (pcl_out),
      .o_stack_depth (stack_depth),
      .o_stack_ovf   (stack_ovf),
      .o_stack_unf   (stack_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [12:0] pc;
      logic [3:0]  depth;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   logic [12:0] m_pc;
   int          m_sp;
   int          m_depth;
   logic        m_ovf, m_unf;
   logic [12:0] m_mem [8];
   logic [12:0] ret_addr [9];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic m_push();
      m_mem[m_sp] = m_pc;
      m_sp = (m_sp + 1) % 8;
      if (m_depth == 8) m_ovf = 1'b1;
      else m_depth++;
   endtask

   task automatic m_pop();
      m_sp = (m_sp + 7) % 8;
      m_pc = m_mem[m_sp];
      if (m_depth == 0) m_unf = 1'b1;
      else m_depth--;
   endtask

   task automatic drive(input logic r, input logic inc, input logic gt, input logic cl,
                        input logic rt, input logic it, input logic pw,
                        input logic [10:0] k, input logic [4:0] lath, input logic [7:0] d);
      exp_t e, got;
      rst = r; pc_inc = inc; goto_en = gt; call_en = cl; ret_en = rt; int_en = it;
      pcl_wr_en = pw; k11 = k; pclath = lath; pcl_data = d;
      if (r) begin
         m_pc = 13'h000; m_sp = 0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (it) begin
         m_push(); m_pc = 13'h004;
      end else if (rt) begin
         m_pop();
      end else if (cl) begin
         m_push(); m_pc = {lath[4:3], k};
      end else if (gt) begin
         m_pc = {lath[4:3], k};
      end else if (pw) begin
         m_pc = {lath, d};
      end else if (inc) begin
         m_pc = m_pc + 13'd1;
      end
      e.pc = m_pc; e.depth = 4'(m_depth); e.ovf = m_ovf; e.unf = m_unf;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      rst = 1'b0; pc_inc = 1'b0; goto_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
      int_en = 1'b0; pcl_wr_en = 1'b0;
      got = sb_q.pop_front();
      check("pc",    32'(pc_out),      32'(got.pc));
      check("pcl",   32'(pcl_out),     32'(got.pc[7:0]));
      check("depth", 32'(stack_depth), 32'(got.depth));
      check("ovf",   32'(stack_ovf),   32'(got.ovf));
      check("unf",   32'(stack_unf),   32'(got.unf));
   endtask

   task automatic op_rst();                   drive(1,0,0,0,0,0,0,'0,'0,'0); endtask
   task automatic op_inc();                   drive(0,1,0,0,0,0,0,'0,'0,'0); endtask
   task automatic op_ret();                   drive(0,0,0,0,1,0,0,'0,'0,'0); endtask
   task automatic op_call(input logic [4:0] l, input logic [10:0] k); drive(0,0,0,1,0,0,0,k,l,'0); endtask
   task automatic op_goto(input logic [4:0] l, input logic [10:0] k); drive(0,0,1,0,0,0,0,k,l,'0); endtask
   task automatic op_pcl(input logic [4:0] l, input logic [7:0] d);   drive(0,0,0,0,0,0,1,'0,l,d); endtask

   initial begin
      rst = 1'b1; pc_inc = 0; goto_en = 0; call_en = 0; ret_en = 0; int_en = 0;
      pcl_wr_en = 0; k11 = '0; pclath = '0; pcl_data = '0;
      m_pc = '0; m_sp = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
      repeat (2) @(posedge clk);
      #1;

      op_rst();
      check("reset_pc", 32'(pc_out), 32'h000);
      check("reset_depth", 32'(stack_depth), 32'd0);
      op_inc(); check("inc1", 32'(pc_out), 32'h001);
      op_inc(); check("inc2", 32'(pc_out), 32'h002);
      op_inc(); check("inc3", 32'(pc_out), 32'h003);
      check("inc3_pcl", 32'(pcl_out), 32'h03);

      op_pcl(5'h00, 8'h10);
      op_call(5'b11000, 11'h123);
      check("call_pc", 32'(pc_out), 32'h1923);
      check("call_depth", 32'(stack_depth), 32'd1);
      op_ret();
      check("ret_pc", 32'(pc_out), 32'h010);
      check("ret_depth", 32'(stack_depth), 32'd0);

      for (int i = 0; i < 9; i++) begin
         op_pcl(5'(i + 1), 8'(8'h20 + i * 8'h11));
         ret_addr[i] = {5'(i + 1), 8'(8'h20 + i * 8'h11)};
         op_call(5'b01000, 11'(11'h200 + i));
      end
      check("nest_ovf", 32'(stack_ovf), 32'd1);
      check("nest_depth", 32'(stack_depth), 32'd8);
      for (int i = 8; i >= 1; i--) begin
         op_ret();
         check("nest_ret", 32'(pc_out), 32'(ret_addr[i]));
      end
      check("nest_unf_clear", 32'(stack_unf), 32'd0);
      op_ret();
      check("wrap_ret", 32'(pc_out), 32'(ret_addr[8]));
      check("wrap_unf", 32'(stack_unf), 32'd1);
      check("wrap_depth", 32'(stack_depth), 32'd0);

      op_pcl(5'h1F, 8'hAB);
      check("pcl_wr", 32'(pc_out), 32'h1FAB);
      op_pcl(5'h1F, 8'hFF);
      op_inc();
      check("inc_wrap", 32'(pc_out), 32'h0000);

      op_goto(5'b01000, 11'h7FF);
      check("goto", 32'(pc_out), 32'h0FFF);
      drive(0,1,1,1,0,0,1, 11'h055, 5'b10000, 8'h77);
      check("call_beats_goto", 32'(pc_out), 32'h1055);
      drive(0,1,1,0,0,0,1, 11'h066, 5'b00111, 8'h12);
      check("goto_beats_pcl", 32'(pc_out), 32'h0066);
      op_ret();

      op_pcl(5'h00, 8'h50);
      drive(0,1,0,0,1,1,0, '0, '0, '0);
      check("int_pc", 32'(pc_out), 32'h004);
      check("int_depth", 32'(stack_depth), 32'd1);
      op_ret();
      check("int_ret", 32'(pc_out), 32'h050);

      for (int i = 0; i < 60; i++) begin
         drive(0, 1'($urandom), 1'($urandom_range(0,3) == 0), 1'($urandom_range(0,3) == 0),
               1'($urandom_range(0,3) == 0), 1'($urandom_range(0,7) == 0),
               1'($urandom_range(0,3) == 0),
               11'($urandom), 5'($urandom), 8'($urandom));
      end

      op_call(5'b11000, 11'h111);
      drive(1,0,0,1,0,0,0, 11'h123, 5'b11000, '0);
      check("rst_call_pc", 32'(pc_out), 32'h000);
      check("rst_call_depth", 32'(stack_depth), 32'd0);
      check("rst_call_ovf", 32'(stack_ovf), 32'd0);
      check("rst_call_unf", 32'(stack_unf), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
